// File: rtl/div_adder_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_adder_seq_if
//  Purpose  : Operation, result and shared-adder signals of div_adder_seq.
//  Revision : 1.0  initial release
// ============================================================================
interface div_adder_seq_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic              in_signed;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_q;
   logic [DATA_W-1:0] out_r;
   logic              out_dbz;
   logic              add_req;
   logic              add_gnt;
   logic              add_cin;
   logic [DATA_W-1:0] add_a;
   logic [DATA_W-1:0] add_b;
   logic [DATA_W-1:0] add_o;
   logic              add_carry;
   logic              flush;

   // Environment side: issues ops, consumes results, owns the adder/arbiter.
   modport master (
      output in_valid, in_signed, in_a, in_b, out_ready,
      output add_gnt, add_o, add_carry, flush,
      input  in_ready, out_valid, out_q, out_r, out_dbz,
      input  add_req, add_cin, add_a, add_b
   );

   // Sequencer side.
   modport slave (
      input  in_valid, in_signed, in_a, in_b, out_ready,
      input  add_gnt, add_o, add_carry, flush,
      output in_ready, out_valid, out_q, out_r, out_dbz,
      output add_req, add_cin, add_a, add_b
   );
endinterface
`default_nettype wire

// File: rtl/div_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_adder_seq
//  Purpose  : 32-bit restoring DIV/DIVU sequencer using a borrowed ALU adder.
//             Optional macro DIV_SEQ_FLUSH_EN enables the flush input.
//  Revision : 1.0  initial release
// ============================================================================
module div_adder_seq #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic            clk,
   input  logic            resetn,
   div_adder_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ABS_A = 3'd1,
      S_ABS_B = 3'd2,
      S_ITER  = 3'd3,
      S_FIX_Q = 3'd4,
      S_FIX_R = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_dvd;
   logic [DATA_W-1:0] r_div;
   logic [DATA_W-1:0] r_rem;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_neg_a;
   logic              r_neg_b;
   logic [DATA_W-1:0] r_out_q;
   logic [DATA_W-1:0] r_out_r;
   logic              r_out_dbz;

   logic              w_flush;
   logic              w_need_add;
   logic              w_req;
   logic              w_step;
   logic              w_qbit;
   logic [DATA_W-1:0] w_rem_sh;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;

`ifdef DIV_SEQ_FLUSH_EN
   assign w_flush = bus.flush;
`else
   logic w_unused_flush;
   assign w_unused_flush = bus.flush;
   assign w_flush        = 1'b0;
`endif

   // Low word of {rem,dvd} << 1; the bit shifted out of rem is r_rem[MSB].
   assign w_rem_sh = {r_rem[DATA_W-2:0], r_dvd[DATA_W-1]};
   assign w_qbit   = r_rem[DATA_W-1] | bus.add_carry;

   always_comb begin
      w_need_add = 1'b0;
      w_op_a     = '0;
      w_op_b     = '0;
      case (r_state)
         S_ABS_A: begin
            w_need_add = r_neg_a;
            w_op_b     = r_dvd;
         end
         S_ABS_B: begin
            w_need_add = r_neg_b;
            w_op_b     = r_div;
         end
         S_ITER: begin
            w_need_add = 1'b1;
            w_op_a     = w_rem_sh;
            w_op_b     = r_div;
         end
         S_FIX_Q: begin
            w_need_add = r_neg_a ^ r_neg_b;
            w_op_b     = r_dvd;
         end
         S_FIX_R: begin
            w_need_add = r_neg_a;
            w_op_b     = r_rem;
         end
         default: begin
            w_need_add = 1'b0;
         end
      endcase
   end

   // Every adder use is a subtraction (negate = 0 - x, trial = rem - div).
   assign w_req        = w_need_add & ~w_flush;
   assign w_step       = ~w_need_add | bus.add_gnt;
   assign bus.add_req  = w_req;
   assign bus.add_cin  = w_req;
   assign bus.add_a    = w_req ? w_op_a : '0;
   assign bus.add_b    = w_req ? w_op_b : '0;

   assign bus.in_ready  = (r_state == S_IDLE) & ~w_flush;
   assign bus.out_valid = (r_state == S_DONE) & ~w_flush;
   assign bus.out_q     = r_out_q;
   assign bus.out_r     = r_out_r;
   assign bus.out_dbz   = r_out_dbz;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_dvd     <= '0;
         r_div     <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_neg_a   <= 1'b0;
         r_neg_b   <= 1'b0;
         r_out_q   <= '0;
         r_out_r   <= '0;
         r_out_dbz <= 1'b0;
      end else if (w_flush) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_dvd   <= bus.in_a;
                  r_div   <= bus.in_b;
                  r_rem   <= '0;
                  r_cnt   <= '1;
                  r_neg_a <= bus.in_signed & bus.in_a[DATA_W-1];
                  r_neg_b <= bus.in_signed & bus.in_b[DATA_W-1];
                  if (bus.in_b == '0) begin
                     r_out_q   <= '1;
                     r_out_r   <= bus.in_a;
                     r_out_dbz <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_state <= S_ABS_A;
                  end
               end
            end
            S_ABS_A: begin
               if (w_step) begin
                  if (w_need_add) r_dvd <= bus.add_o;
                  r_state <= S_ABS_B;
               end
            end
            S_ABS_B: begin
               if (w_step) begin
                  if (w_need_add) r_div <= bus.add_o;
                  r_state <= S_ITER;
               end
            end
            S_ITER: begin
               if (bus.add_gnt) begin
                  r_rem <= w_qbit ? bus.add_o : w_rem_sh;
                  r_dvd <= {r_dvd[DATA_W-2:0], w_qbit};
                  if (r_cnt == '0) begin
                     r_state <= S_FIX_Q;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
            end
            S_FIX_Q: begin
               if (w_step) begin
                  if (w_need_add) r_dvd <= bus.add_o;
                  r_state <= S_FIX_R;
               end
            end
            S_FIX_R: begin
               if (w_step) begin
                  r_out_q   <= r_dvd;
                  r_out_r   <= w_need_add ? bus.add_o : r_rem;
                  r_out_dbz <= 1'b0;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
